// File: rtl/data_mem_banked.sv
// -----------------------------------------------------------------------------
// data_mem_banked
//   Byte-addressed RV32I data memory for the MEM stage. Storage is four
//   byte-lane banks, so every aligned access is one pass over the array. A
//   request is accepted with req_i && ready_o, and done_o pulses for one cycle
//   after LATENCY cycles. Out-of-range accesses (and misaligned ones when
//   split support is absent) complete with err_o=1, no write and zero data.
//
// Parameters
//   DEPTH   : size in bytes, power of two, >= 8
//   LATENCY : cycles from acceptance to done_o for a single pass, 1..15
//
// Ports
//   clk_i        in   clock, rising edge
//   rst_i        in   synchronous active-high reset
//   req_i        in   access request
//   we_i         in   1 = store, 0 = load (sampled at acceptance)
//   addr_i       in   [31:0] byte address (sampled at acceptance)
//   data_type_i  in   [2:0] MEM_TYPE_* code; unknown codes behave as INT32
//   data_wr_i    in   [31:0] store data, low-aligned
//   ready_o      out  idle, able to accept
//   done_o       out  one-cycle completion pulse
//   data_rd_o    out  [31:0] extended load data, 0 unless done_o
//   err_o        out  done_o qualifier: access faulted
//   busy_o       out  !ready_o
//
// Configuration
//   DMEM_MISALIGN_SPLIT_EN : when defined, misaligned accesses are supported;
//   word-crossing accesses take a second pass through the SPLIT state.
// -----------------------------------------------------------------------------
module data_mem_banked #(
  parameter int DEPTH   = 2048,
  parameter int LATENCY = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [2:0]  data_type_i,
  input  logic [31:0] data_wr_i,
  output logic        ready_o,
  output logic        done_o,
  output logic [31:0] data_rd_o,
  output logic        err_o,
  output logic        busy_o
);

  // Load/store width codes (RV32I funct3 encoding, as in ConstantDefine.v).
  localparam logic [2:0] MEM_TYPE_INT8   = 3'd0;
  localparam logic [2:0] MEM_TYPE_INT16  = 3'd1;
  localparam logic [2:0] MEM_TYPE_INT32  = 3'd2;
  localparam logic [2:0] MEM_TYPE_UINT8  = 3'd4;
  localparam logic [2:0] MEM_TYPE_UINT16 = 3'd5;

  localparam int AW         = $clog2(DEPTH);
  localparam int WW         = AW - 2;
  localparam int BANK_DEPTH = DEPTH / 4;
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE,
`ifdef DMEM_MISALIGN_SPLIT_EN
    S_SPLIT,
`endif
    S_WAIT,
    S_RESP
  } state_t;

  // State entered once the last array pass is done.
  localparam state_t S_AFTER_PASS = (LATENCY == 1) ? S_RESP : S_WAIT;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [3:0]  r_cnt;
  logic        r_err;
  logic [2:0]  r_type;
  logic [31:0] r_raw;        // load bytes, little-endian, before extension

  // NOTE: array contents are never reset; a reset term would turn the banks
  // into flops instead of RAM, and software never relies on initial values.
  logic [7:0]  r_bank [4][BANK_DEPTH];

  logic          w_accept;
  logic [2:0]    w_width;
  logic [1:0]    w_off;
  logic [WW-1:0] w_word;
  logic [32:0]   w_end;
  logic          w_err;
  logic [3:0]    w_p1_byte;  // access byte k is handled in pass 1
  logic [1:0]    w_lane [4]; // bank holding access byte k
  logic [31:0]   w_ext;

`ifdef DMEM_MISALIGN_SPLIT_EN
  logic          r_we;
  logic [1:0]    r_off;
  logic [2:0]    r_width;
  logic [31:0]   r_data;
  logic [WW-1:0] r_word_nxt;
  logic          w_split;
  logic [3:0]    w_p2_byte;
  logic [1:0]    w_lane2 [4];
`endif

  // ---------------------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------------------
  assign w_accept = req_i && (r_state == S_IDLE);
  assign w_off    = addr_i[1:0];
  assign w_word   = addr_i[AW-1:2];

  // NOTE: every always_comb output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    w_width = 3'd4;
    case (data_type_i)
      MEM_TYPE_INT16, MEM_TYPE_UINT16: w_width = 3'd2;
      MEM_TYPE_INT8,  MEM_TYPE_UINT8:  w_width = 3'd1;
      default:                         w_width = 3'd4;
    endcase
  end

  // Last byte address in 33 bits so a high address cannot wrap into range.
  assign w_end = {1'b0, addr_i} + 33'(w_width) - 33'd1;

`ifdef DMEM_MISALIGN_SPLIT_EN
  assign w_err   = !(w_end < 33'(DEPTH));
  assign w_split = ((3'(w_off) + w_width) > 3'd4) && !w_err;
`else
  assign w_err   = !(w_end < 33'(DEPTH))
                 || ((w_width == 3'd2) && w_off[0])
                 || ((w_width == 3'd4) && (w_off != 2'd0));
`endif

  // Byte k of the access lives in lane (off + k) mod 4; bytes whose lane
  // number would reach 4 or more belong to the next word (pass 2).
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      w_lane[k]    = w_off + 2'(k);
      w_p1_byte[k] = (k < int'(w_width)) && ((int'(w_off) + k) < 4);
    end
  end

`ifdef DMEM_MISALIGN_SPLIT_EN
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      w_lane2[k]   = r_off + 2'(k);
      w_p2_byte[k] = (k < int'(r_width)) && ((int'(r_off) + k) >= 4);
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (req_i) begin
`ifdef DMEM_MISALIGN_SPLIT_EN
          if (w_split) w_state_nxt = S_SPLIT;
          else
`endif
          w_state_nxt = S_AFTER_PASS;
        end
      end
`ifdef DMEM_MISALIGN_SPLIT_EN
      S_SPLIT: w_state_nxt = S_AFTER_PASS;
`endif
      // The counter hits zero on the edge that leaves WAIT.
      S_WAIT:  if (r_cnt == 4'd1) w_state_nxt = S_RESP;
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
      r_cnt   <= CNT_INIT;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= (r_state == S_WAIT) ? (r_cnt - 4'd1) : CNT_INIT;
    end
  end

  // ---------------------------------------------------------------------------
  // Access bookkeeping and load capture
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_err  <= 1'b0;
      r_type <= MEM_TYPE_INT32;
      r_raw  <= '0;
    end else if (w_accept) begin
      r_err  <= w_err;
      r_type <= data_type_i;
      r_raw  <= '0;
`ifdef DMEM_MISALIGN_SPLIT_EN
      r_we       <= we_i;
      r_off      <= w_off;
      r_width    <= w_width;
      r_data     <= data_wr_i;
      r_word_nxt <= w_word + {{(WW-1){1'b0}}, 1'b1};
`endif
      if (!we_i && !w_err) begin
        for (int k = 0; k < 4; k++) begin
          if (w_p1_byte[k]) r_raw[8*k +: 8] <= r_bank[w_lane[k]][w_word];
        end
      end
    end
`ifdef DMEM_MISALIGN_SPLIT_EN
    else if ((r_state == S_SPLIT) && !r_we) begin
      for (int k = 0; k < 4; k++) begin
        if (w_p2_byte[k]) r_raw[8*k +: 8] <= r_bank[w_lane2[k]][r_word_nxt];
      end
    end
`endif
  end

  // ---------------------------------------------------------------------------
  // Bank writes. Reset blocks new commits, which also drops a pending pass 2.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      if (w_accept && we_i && !w_err) begin
        for (int k = 0; k < 4; k++) begin
          if (w_p1_byte[k]) r_bank[w_lane[k]][w_word] <= data_wr_i[8*k +: 8];
        end
      end
`ifdef DMEM_MISALIGN_SPLIT_EN
      if ((r_state == S_SPLIT) && r_we) begin
        for (int k = 0; k < 4; k++) begin
          if (w_p2_byte[k]) r_bank[w_lane2[k]][r_word_nxt] <= r_data[8*k +: 8];
        end
      end
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Load extension and outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    w_ext = r_raw;
    case (r_type)
      MEM_TYPE_INT8:   w_ext = {{24{r_raw[7]}}, r_raw[7:0]};
      MEM_TYPE_UINT8:  w_ext = {24'd0, r_raw[7:0]};
      MEM_TYPE_INT16:  w_ext = {{16{r_raw[15]}}, r_raw[15:0]};
      MEM_TYPE_UINT16: w_ext = {16'd0, r_raw[15:0]};
      default:         w_ext = r_raw;
    endcase
  end

  assign ready_o   = (r_state == S_IDLE);
  assign busy_o    = !ready_o;
  assign done_o    = (r_state == S_RESP);
  assign err_o     = done_o && r_err;
  assign data_rd_o = (done_o && !r_err) ? w_ext : 32'd0;

endmodule

// File: tb/tb_data_mem_banked.sv
// -----------------------------------------------------------------------------
// tb_data_mem_banked
//   Directed bench for data_mem_banked with DEPTH=2048, LATENCY=2. Inputs are
//   driven on the falling edge, outputs sampled on the falling edge. Expected
//   values are hand-computed constants; split-build expectations are selected
//   with DMEM_MISALIGN_SPLIT_EN.
// -----------------------------------------------------------------------------
module tb_data_mem_banked;

  localparam logic [2:0] T_INT8   = 3'd0;
  localparam logic [2:0] T_INT16  = 3'd1;
  localparam logic [2:0] T_INT32  = 3'd2;
  localparam logic [2:0] T_UINT8  = 3'd4;
  localparam logic [2:0] T_UINT16 = 3'd5;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        req_i = 1'b0;
  logic        we_i = 1'b0;
  logic [31:0] addr_i = '0;
  logic [2:0]  data_type_i = T_INT32;
  logic [31:0] data_wr_i = '0;
  logic        ready_o, done_o, err_o, busy_o;
  logic [31:0] data_rd_o;

  int n_vec = 0;
  int n_bad = 0;

  data_mem_banked #(.DEPTH(2048), .LATENCY(2)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .req_i       (req_i),
    .we_i        (we_i),
    .addr_i      (addr_i),
    .data_type_i (data_type_i),
    .data_wr_i   (data_wr_i),
    .ready_o     (ready_o),
    .done_o      (done_o),
    .data_rd_o   (data_rd_o),
    .err_o       (err_o),
    .busy_o      (busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One complete access: drive, wait (bounded) for done_o, check the result.
  task automatic op(input string tag, input logic we, input logic [31:0] addr,
                    input logic [2:0] ty, input logic [31:0] wd, input logic chk_rd,
                    input logic [31:0] exp_rd, input logic exp_err, input int exp_lat);
    int          lat;
    logic [31:0] rd;
    logic        er;
    @(negedge clk_i);
    check({tag, ".idle"}, {30'd0, ready_o, done_o}, 32'h2);
    req_i = 1'b1; we_i = we; addr_i = addr; data_type_i = ty; data_wr_i = wd;
    @(posedge clk_i);
    #1 req_i = 1'b0;
    lat = 0; rd = '0; er = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk_i);
      if (done_o) begin
        lat = n; rd = data_rd_o; er = err_o;
        break;
      end
    end
    check({tag, ".lat"}, 32'(lat), 32'(exp_lat));
    check({tag, ".err"}, {31'd0, er}, {31'd0, exp_err});
    if (chk_rd) check({tag, ".data"}, rd, exp_rd);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [5:0] done_bits;
    logic [5:0] ready_bits;
    logic       done_seen;

    // Reset state
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    check("rst.ready", {31'd0, ready_o}, 32'd1);
    check("rst.done",  {31'd0, done_o},  32'd0);
    check("rst.err",   {31'd0, err_o},   32'd0);
    check("rst.busy",  {31'd0, busy_o},  32'd0);
    check("rst.data",  data_rd_o,        32'd0);

    // Preload zeros to the words used by the misaligned tests
    op("pre20", 1'b1, 32'h20, T_INT32, 32'h0, 1'b0, 32'h0, 1'b0, 2);
    op("pre24", 1'b1, 32'h24, T_INT32, 32'h0, 1'b0, 32'h0, 1'b0, 2);

    // Word store and sub-word loads with extension
    op("st10",    1'b1, 32'h10, T_INT32,  32'h8000_00FF, 1'b0, 32'h0, 1'b0, 2);
    op("ld_i8",   1'b0, 32'h10, T_INT8,   32'h0, 1'b1, 32'hFFFF_FFFF, 1'b0, 2);
    op("ld_u8",   1'b0, 32'h10, T_UINT8,  32'h0, 1'b1, 32'h0000_00FF, 1'b0, 2);
    op("ld_i16",  1'b0, 32'h12, T_INT16,  32'h0, 1'b1, 32'hFFFF_8000, 1'b0, 2);
    op("ld_u16",  1'b0, 32'h12, T_UINT16, 32'h0, 1'b1, 32'h0000_8000, 1'b0, 2);

    // Byte store touches one lane only; upper store data bits are ignored
    op("st_b11",  1'b1, 32'h11, T_INT8,   32'h1234_56AB, 1'b0, 32'h0, 1'b0, 2);
    op("ld_w10",  1'b0, 32'h10, T_INT32,  32'h0, 1'b1, 32'h8000_ABFF, 1'b0, 2);

    // Misaligned accesses
`ifdef DMEM_MISALIGN_SPLIT_EN
    op("st_w23",  1'b1, 32'h23, T_INT32,  32'h4433_2211, 1'b0, 32'h0, 1'b0, 3);
    op("ld_w23",  1'b0, 32'h23, T_INT32,  32'h0, 1'b1, 32'h4433_2211, 1'b0, 3);
    op("ld_w20",  1'b0, 32'h20, T_INT32,  32'h0, 1'b1, 32'h1100_0000, 1'b0, 2);
    op("ld_w24",  1'b0, 32'h24, T_INT32,  32'h0, 1'b1, 32'h0044_3322, 1'b0, 2);
    op("ld_h11",  1'b0, 32'h11, T_UINT16, 32'h0, 1'b1, 32'h0000_00AB, 1'b0, 2);
`else
    op("st_w23",  1'b1, 32'h23, T_INT32,  32'h4433_2211, 1'b0, 32'h0, 1'b1, 2);
    op("ld_w20",  1'b0, 32'h20, T_INT32,  32'h0, 1'b1, 32'h0000_0000, 1'b0, 2);
    op("ld_w24",  1'b0, 32'h24, T_INT32,  32'h0, 1'b1, 32'h0000_0000, 1'b0, 2);
    op("ld_h11",  1'b0, 32'h11, T_UINT16, 32'h0, 1'b1, 32'h0000_0000, 1'b1, 2);
`endif

    // Range boundary
    op("st_7fc",  1'b1, 32'h7FC, T_INT32, 32'hDEAD_BEEF, 1'b0, 32'h0, 1'b0, 2);
    op("ld_7fc",  1'b0, 32'h7FC, T_INT32, 32'h0, 1'b1, 32'hDEAD_BEEF, 1'b0, 2);
    op("ld_7fe",  1'b0, 32'h7FE, T_INT32, 32'h0, 1'b1, 32'h0, 1'b1, 2);
    op("ld_800",  1'b0, 32'h800, T_INT32, 32'h0, 1'b1, 32'h0, 1'b1, 2);
    op("st_7fe",  1'b1, 32'h7FE, T_INT32, 32'h1111_1111, 1'b0, 32'h0, 1'b1, 2);
    op("st_ffff", 1'b1, 32'hFFFF_FFFF, T_INT8, 32'h22, 1'b0, 32'h0, 1'b1, 2);
    op("ld_7ffh", 1'b0, 32'h7FE, T_UINT16, 32'h0, 1'b1, 32'h0000_DEAD, 1'b0, 2);
    op("ld_7ffb", 1'b0, 32'h7FF, T_UINT8,  32'h0, 1'b1, 32'h0000_00DE, 1'b0, 2);

    // Reset during WAIT of a load
    @(negedge clk_i);
    req_i = 1'b1; we_i = 1'b0; addr_i = 32'h10; data_type_i = T_INT32;
    @(posedge clk_i);
    #1 req_i = 1'b0;
    @(negedge clk_i);
    check("rstw.busy", {31'd0, busy_o}, 32'd1);
    rst_i = 1'b1;
    @(negedge clk_i);
    check("rstw.ready", {31'd0, ready_o}, 32'd1);
    check("rstw.done",  {31'd0, done_o},  32'd0);
    rst_i = 1'b0;
    done_seen = 1'b0;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk_i);
      done_seen = done_seen | done_o;
    end
    check("rstw.nodone", {31'd0, done_seen}, 32'd0);

    // Request held high while busy: second access only starts once idle
    @(negedge clk_i);
    req_i = 1'b1; we_i = 1'b1; addr_i = 32'h30; data_type_i = T_INT32;
    data_wr_i = 32'h5555_AAAA;
    @(posedge clk_i);
    done_bits = '0; ready_bits = '0;
    for (int n = 1; n <= 6; n++) begin
      @(negedge clk_i);
      done_bits[n-1]  = done_o;
      ready_bits[n-1] = ready_o;
      if (n == 1) begin addr_i = 32'h34; data_wr_i = 32'h7777_7777; end
      if (n == 4) req_i = 1'b0;
    end
    check("hold.done",  {26'd0, done_bits},  32'h12);
    check("hold.ready", {26'd0, ready_bits}, 32'h24);
    op("ld_w30", 1'b0, 32'h30, T_INT32, 32'h0, 1'b1, 32'h5555_AAAA, 1'b0, 2);
    op("ld_w34", 1'b0, 32'h34, T_INT32, 32'h0, 1'b1, 32'h7777_7777, 1'b0, 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
